// File: rtl/ravenna_dac_seq.sv
// Sample sequencer feeding the 10-bit DAC: CPU-filled code FIFO drained
// at a programmable rate, with underrun/overflow flags and a half-empty irq.
module ravenna_dac_seq #(
  parameter int DEPTH = 16,
  parameter int DIVW  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_we,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic [31:0] stat_rdata,
  input  logic        dat_we,
  input  logic [9:0]  dat_wdata,
  output logic        dat_ready,
  output logic [9:0]  dac_value,
  output logic        dac_ena,
  output logic        irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;

  logic            enable;
  logic [DIVW-1:0] div, cnt;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic            underrun, overflow;
  logic [9:0]      mem [DEPTH];

  logic full, empty, clr, tick, push, pop;
  logic unused_cfg;

  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign clr        = cfg_we && cfg_wdata[1];
  assign tick       = enable && (cnt == div);
  // full/empty are pre-edge values, so a same-cycle pop never makes room
  // for a push and a same-cycle push never feeds an underrunning tick.
  assign push       = dat_we && !full && !clr;
  assign pop        = tick && !empty && !clr;
  assign unused_cfg = ^cfg_wdata[31:2];

  assign dat_ready = !full;
  assign dac_ena   = enable;
  assign irq       = enable && (level < LW'(DEPTH / 2));

  always_comb begin
    cfg_rdata             = '0;
    cfg_rdata[0]          = enable;
    cfg_rdata[16 +: DIVW] = div;
  end

  always_comb begin
    stat_rdata        = '0;
    stat_rdata[7:0]   = 8'(level);
    stat_rdata[8]     = empty;
    stat_rdata[9]     = full;
    stat_rdata[10]    = underrun;
    stat_rdata[11]    = overflow;
  end

  // Storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dat_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable    <= 1'b0;
      div       <= '0;
      cnt       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
      dac_value <= '0;
    end else begin
      if (cfg_we) begin
        enable <= cfg_wdata[0];
        div    <= cfg_wdata[16 +: DIVW];
        cnt    <= '0;
      end else if (!enable || cnt == div) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIVW'(1);
      end

      if (clr) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        level    <= '0;
        underrun <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr    <= rd_ptr + AW'(1);
          dac_value <= mem[rd_ptr];
        end
        level <= level + LW'(push) - LW'(pop);
        if (dat_we && full) overflow <= 1'b1;
        if (tick && empty)  underrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ravenna_dac_seq.sv
// Scoreboard bench for ravenna_dac_seq: stimulus queues timed expectations,
// a negedge monitor compares the due ones against the DUT outputs.
module tb_ravenna_dac_seq;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata, stat_rdata;
  logic        dat_we = 1'b0;
  logic [9:0]  dat_wdata = '0;
  logic        dat_ready;
  logic [9:0]  dac_value;
  logic        dac_ena, irq;

  ravenna_dac_seq #(.DEPTH(16), .DIVW(16)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .stat_rdata(stat_rdata),
    .dat_we(dat_we), .dat_wdata(dat_wdata), .dat_ready(dat_ready),
    .dac_value(dac_value), .dac_ena(dac_ena), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam int K_DAC = 0, K_STAT = 1, K_CFG = 2, K_RDY = 3, K_IRQ = 4, K_ENA = 5;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(int k);
    case (k)
      K_DAC:   return {22'd0, dac_value};
      K_STAT:  return stat_rdata;
      K_CFG:   return cfg_rdata;
      K_RDY:   return {31'd0, dat_ready};
      K_IRQ:   return {31'd0, irq};
      default: return {31'd0, dac_ena};
    endcase
  endfunction

  function automatic string kname(int k);
    case (k)
      K_DAC:   return "dac_value";
      K_STAT:  return "stat_rdata";
      K_CFG:   return "cfg_rdata";
      K_RDY:   return "dat_ready";
      K_IRQ:   return "irq";
      default: return "dac_ena";
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  exp_t keep[$];
  always @(negedge clk) begin
    logic [31:0] got;
    keep = {};
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        got = observe(q[i].kind);
        n_cmp++;
        if (got !== q[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got 0x%08h want 0x%08h",
                   kname(q[i].kind), cyc, got, q[i].val);
        end
      end else if (q[i].due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s @cyc %0d: check never sampled, want 0x%08h",
                 kname(q[i].kind), q[i].due, q[i].val);
      end else begin
        keep.push_back(q[i]);
      end
    end
    q = keep;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(int kind, logic [31:0] v, int dly);
    exp_t e;
    e.due = cyc + dly; e.kind = kind; e.val = v;
    q.push_back(e);
  endtask

  task automatic cfg(bit en, bit clr, int d);
    cfg_wdata = {16'(d), 14'd0, clr, en};
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic push(logic [9:0] c);
    dat_wdata = c;
    dat_we = 1'b1;
    step();
    dat_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: bench did not complete, got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and release with no stimulus.
    step(); step();
    resetn = 1'b1;
    expect_at(K_DAC, 32'h0, 0);
    expect_at(K_ENA, 32'h0, 0);
    expect_at(K_IRQ, 32'h0, 0);
    expect_at(K_RDY, 32'h1, 0);
    expect_at(K_STAT, 32'h100, 0);
    expect_at(K_CFG, 32'h0, 0);
    step();
    expect_at(K_STAT, 32'h100, 0);

    // Three codes, div=3: pops land 4/8/12 edges after the cfg write.
    push(10'h3FF); push(10'h200); push(10'h001);
    expect_at(K_STAT, 32'h003, 0);
    expect_at(K_IRQ, 32'h0, 0);
    cfg(1'b1, 1'b0, 3);
    expect_at(K_CFG, 32'h0003_0001, 0);
    expect_at(K_ENA, 32'h1, 0);
    expect_at(K_IRQ, 32'h1, 0);
    expect_at(K_DAC, 32'h000, 3);
    expect_at(K_DAC, 32'h3FF, 4);
    expect_at(K_DAC, 32'h3FF, 7);
    expect_at(K_DAC, 32'h200, 8);
    expect_at(K_DAC, 32'h001, 12);
    expect_at(K_STAT, 32'h100, 12);
    expect_at(K_STAT, 32'h500, 16);
    expect_at(K_DAC, 32'h001, 16);
    repeat (17) step();

    // Overflow while disabled.
    cfg(1'b0, 1'b1, 0);
    expect_at(K_STAT, 32'h100, 0);
    expect_at(K_CFG, 32'h0, 0);
    for (int i = 0; i < 16; i++) push(10'(i));
    expect_at(K_STAT, 32'h210, 0);
    expect_at(K_RDY, 32'h0, 0);
    expect_at(K_IRQ, 32'h0, 0);
    push(10'h3AB);
    expect_at(K_STAT, 32'hA10, 0);
    expect_at(K_RDY, 32'h0, 0);
    expect_at(K_IRQ, 32'h0, 0);

    // div=0 with level 4 and a push every cycle: level holds, 4-deep delay.
    cfg(1'b0, 1'b1, 0);
    expect_at(K_STAT, 32'h100, 0);
    for (int i = 0; i < 4; i++) push(10'(12'h100 + i));
    cfg(1'b1, 1'b0, 0);
    expect_at(K_STAT, 32'h004, 0);
    expect_at(K_IRQ, 32'h1, 0);
    for (int n = 1; n <= 12; n++) begin
      dat_wdata = 10'(12'h103 + n);
      dat_we = 1'b1;
      step();
      expect_at(K_DAC, 32'(12'h100 + n - 1), 0);
      expect_at(K_STAT, 32'h004, 0);
    end
    dat_we = 1'b0;
    repeat (5) step();
    expect_at(K_DAC, 32'h10F, 0);
    expect_at(K_STAT, 32'h500, 0);

    // Clear mid-stream with a same-cycle push.
    cfg(1'b0, 1'b1, 0);
    expect_at(K_STAT, 32'h100, 0);
    for (int i = 0; i < 10; i++) push(10'(12'h050 + i));
    cfg(1'b1, 1'b0, 100);
    expect_at(K_STAT, 32'h00A, 0);
    expect_at(K_IRQ, 32'h0, 0);
    cfg_wdata = {16'd100, 14'd0, 1'b1, 1'b1};
    cfg_we = 1'b1;
    dat_wdata = 10'h2AA;
    dat_we = 1'b1;
    step();
    cfg_we = 1'b0;
    dat_we = 1'b0;
    cfg_wdata = '0;
    expect_at(K_STAT, 32'h100, 0);
    expect_at(K_DAC, 32'h10F, 0);
    expect_at(K_CFG, 32'h0064_0001, 0);
    expect_at(K_IRQ, 32'h1, 0);
    expect_at(K_STAT, 32'h100, 100);
    expect_at(K_STAT, 32'h500, 101);
    expect_at(K_DAC, 32'h10F, 101);
    repeat (101) step();

    // Async reset between edges while running.
    push(10'h155);
    cfg(1'b1, 1'b0, 2);
    push(10'h0AA);
    expect_at(K_DAC, 32'h155, 2);
    step(); step(); step();
    resetn = 1'b0;
    expect_at(K_DAC, 32'h0, 0);
    expect_at(K_ENA, 32'h0, 0);
    expect_at(K_IRQ, 32'h0, 0);
    expect_at(K_STAT, 32'h100, 0);
    expect_at(K_RDY, 32'h1, 0);
    expect_at(K_CFG, 32'h0, 0);
    step(); step();
    resetn = 1'b1;
    step();
    expect_at(K_STAT, 32'h100, 0);
    expect_at(K_CFG, 32'h0, 0);
    expect_at(K_DAC, 32'h0, 0);

    repeat (3) step();
    foreach (q[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s @cyc %0d: left unchecked, want 0x%08h",
               kname(q[i].kind), q[i].due, q[i].val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
